// File: rtl/uart_tx_frame.sv
// uart_tx_frame: valid/ready UART transmit framer with internal baud divider.
// Optional line-break generation is enabled with `define UART_TX_BREAK_EN.
module uart_tx_frame #(
  parameter int BAUD_DIV    = 5208,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk_req,
`endif
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(BAUD_DIV);
  generate
    if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
      $error("uart_tx_frame: illegal parameter value");
    end
  endgenerate
`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK, MARK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           bits, bits_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par, par_n, tx_n, done_n, bit_end, accept;
  assign tx_ready = state == IDLE;
  assign busy     = state != IDLE;
  assign accept   = tx_valid & tx_ready;
  assign bit_end  = cnt == CW'(BAUD_DIV - 1);
  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? '0 : cnt + 1'b1;
    bits_n  = bits;
    shift_n = shift;
    par_n   = par;
    tx_n    = tx;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (accept) begin
          state_n = START;
          shift_n = tx_data;
          par_n   = ^tx_data ^ 1'(PARITY_MODE == 1);
          bits_n  = '0;
          tx_n    = 1'b0;
        end
`ifdef UART_TX_BREAK_EN
        else if (brk_req) begin
          state_n = BRK;
          tx_n    = 1'b0;
        end
`endif
      end
      START: if (bit_end) begin
        state_n = DATA;
        tx_n    = shift[0];
      end
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        if (bits == 4'(DATA_BITS - 1)) begin
          bits_n  = '0;
          state_n = PARITY_MODE != 0 ? PARITY : STOP;
          tx_n    = PARITY_MODE != 0 ? par : 1'b1;
        end else begin
          bits_n = bits + 1'b1;
          tx_n   = shift[1];
        end
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        tx_n    = 1'b1;
      end
      STOP: if (bit_end) begin
        bits_n  = bits == 4'(STOP_BITS - 1) ? '0 : bits + 1'b1;
        state_n = bits == 4'(STOP_BITS - 1) ? IDLE : STOP;
        done_n  = bits == 4'(STOP_BITS - 1);
      end
`ifdef UART_TX_BREAK_EN
      BRK: begin
        cnt_n = '0;
        if (!brk_req) begin
          state_n = MARK;
          tx_n    = 1'b1;
        end
      end
      MARK: if (bit_end) state_n = IDLE;
`endif
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bits  <= '0;
      shift <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bits  <= bits_n;
      shift <= shift_n;
      par   <= par_n;
      tx    <= tx_n;
      done  <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed checks of two framer configurations (8N1 and 8O2, 4 clocks per bit).
module tb_uart_tx_frame;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] da = '0, db = '0;
  logic       va = 1'b0, vb = 1'b0, brk = 1'b0, brk_b = 1'b0;
  logic       ra, txa, ba, dna, rb, txb, bb, dnb;
  int         n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(da), .tx_valid(va),
`ifdef UART_TX_BREAK_EN
    .brk_req(brk),
`endif
    .tx_ready(ra), .tx(txa), .busy(ba), .done(dna));
  uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(db), .tx_valid(vb),
`ifdef UART_TX_BREAK_EN
    .brk_req(brk_b),
`endif
    .tx_ready(rb), .tx(txb), .busy(bb), .done(dnb));
  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  // Entered on the negedge of the first start-bit cycle; returns on the done cycle.
  task automatic frame(input string tag, input logic sel, input logic [11:0] exp, input int n);
    for (int i = 0; i < n * 4; i++) begin
      chk({tag, "_tx"}, sel ? txb : txa, exp[i/4]);
      chk({tag, "_done_low"}, sel ? dnb : dna, 1'b0);
      if (i == 5) begin
        chk({tag, "_ready_low"}, sel ? rb : ra, 1'b0);
        chk({tag, "_busy_high"}, sel ? bb : ba, 1'b1);
      end
      @(negedge clk);
    end
    chk({tag, "_done_pulse"}, sel ? dnb : dna, 1'b1);
    chk({tag, "_ready_on_done"}, sel ? rb : ra, 1'b1);
    chk({tag, "_tx_idle"}, sel ? txb : txa, 1'b1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", txa, 1'b1);
    chk("rst_ready", ra, 1'b1);
    chk("rst_busy", ba, 1'b0);
    chk("rst_done", dna, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_tx", txa, 1'b1);
      chk("idle_ready", ra, 1'b1);
      chk("idle_busy", ba, 1'b0);
      chk("idle_done", dna, 1'b0);
    end
    da = 8'hA5; va = 1'b1;
    @(negedge clk);
    va = 1'b0; da = 8'h00;
    frame("a5", 1'b0, 12'b0000_1101001010, 10);
    @(negedge clk);
    chk("a5_done_one_cycle", dna, 1'b0);
    db = 8'h07; vb = 1'b1;
    @(negedge clk);
    vb = 1'b0;
    frame("p07", 1'b1, 12'b1100_0000_1110, 12);
    @(negedge clk);
    db = 8'h03; vb = 1'b1;
    @(negedge clk);
    vb = 1'b0;
    frame("p03", 1'b1, 12'b1110_0000_0110, 12);
    @(negedge clk);
    da = 8'h55; va = 1'b1;
    @(negedge clk);
    da = 8'hFF;
    frame("b2b_55", 1'b0, 12'b0000_1010101010, 10);
    @(negedge clk);
    va = 1'b0;
    frame("b2b_ff", 1'b0, 12'b0011_1111_1110, 10);
    @(negedge clk);
    chk("b2b_no_third", ba, 1'b0);
    da = 8'h3C; va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_rst_busy", ba, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", txa, 1'b1);
    chk("midrst_ready", ra, 1'b1);
    chk("midrst_busy", ba, 1'b0);
    chk("midrst_done", dna, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_tx", txa, 1'b1);
    da = 8'h3C; va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    frame("r3c", 1'b0, 12'b0010_0111_1000, 10);
`ifdef UART_TX_BREAK_EN
    @(negedge clk);
    brk = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk("brk_tx_low", txa, 1'b0);
      chk("brk_ready_low", ra, 1'b0);
      if (i == 19) brk = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      chk("mab_tx_high", txa, 1'b1);
      chk("mab_ready_low", ra, 1'b0);
      chk("mab_no_done", dna, 1'b0);
      @(negedge clk);
    end
    chk("brk_end_ready", ra, 1'b1);
    chk("brk_end_no_done", dna, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised UART transmit framer, the successor to the fixed 8-bit transmit FSM.
- Accepts a parallel word over a valid/ready handshake and serialises it LSB-first as start, data, optional parity and 1–2 stop bits.
- Bit timing comes from an internal baud divider, so no external tick generator is needed.
- Sits between the host/register interface and the physical TX pin.

Parameters:
- BAUD_DIV, 5208, clocks per bit (50 MHz / 9600); legal range ≥2.
- DATA_BITS, 8, data bits per frame; legal range 5–9.
- PARITY_MODE, 0: 0=none, 1=odd, 2=even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_BITS  word to send; sampled only on accept.
- tx_valid  in  1  word available.
- tx_ready  out  1  block can accept; high only in IDLE.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress (any state other than IDLE).
- done  out  1  one-cycle pulse at end of the last stop bit.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, tx=1, tx_ready=1, busy=0, done=0, baud counter=0, bit counter=0, shift register=0. Reset mid-frame aborts immediately; tx returns high with no partial stop bit.
- Accept: tx_valid & tx_ready on a rising clk edge. tx_data is latched into the shift register, parity is computed from the latched word, baud counter is cleared, and the state goes to START. tx goes low the cycle after accept. tx_data changes after accept have no effect.
- Baud counter: counts 0..BAUD_DIV-1 and wraps. A bit ends when the count equals BAUD_DIV-1. Every bit lasts exactly BAUD_DIV clocks.
- States:
  - IDLE: tx=1.
  - START: tx=0, for one bit time.
  - DATA: tx=shift[0]. Shift right at each bit end. Bit counter runs 0..DATA_BITS-1, then goes to PARITY if PARITY_MODE≠0, else to STOP.
  - PARITY: tx = XOR of data bits, inverted for odd. So for odd mode the total count of 1s across data+parity is odd; for even mode it is even. One bit time.
  - STOP: tx=1 for STOP_BITS bit times. At the end of the last stop bit: done=1 for one cycle, state returns to IDLE, tx_ready=1 on that same cycle.
- Frame length: (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) × BAUD_DIV clocks, from the first tx=0 cycle to the done pulse.
- Back-to-back: if tx_valid is held, the next accept occurs on the cycle done is high. The next start bit follows with no idle gap. Total spacing is exactly the frame length.
- tx_valid in a non-IDLE state is ignored and not queued; tx_ready=0.
- tx and done are registered outputs. tx_ready and busy are decoded from the state register.
- Illegal parameter values (DATA_BITS outside 5–9, STOP_BITS not 1/2, PARITY_MODE>2) are stopped with an elaboration-time check.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined: adds input brk_req (1 bit) and state BREAK.
  - brk_req=1 in IDLE, when no accept happens that cycle, enters BREAK; accept wins if both occur together.
  - BREAK drives tx=0 and tx_ready=0 while brk_req stays high.
  - On deassertion, tx=1 is held for one full bit time (mark-after-break), then the state returns to IDLE. done is not pulsed.
  - brk_req during a frame is ignored until IDLE.
- Undefined: no brk_req port, no BREAK state; behaviour is exactly as above.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> tx=1, tx_ready=1, busy=0, done=0, stable for 100 cycles.
- Basic frame (BAUD_DIV=4, DATA_BITS=8, PARITY_MODE=0, STOP_BITS=1): send 0xA5 -> tx over 40 cycles = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. done pulses once at cycle 40; tx_ready returns on that cycle.
- Parity + 2 stop (PARITY_MODE=1, STOP_BITS=2, BAUD_DIV=4): 0x07 -> parity bit=0. 0x03 -> parity bit=1. Frame = 48 cycles.
- Back-to-back: tx_valid held with 0x55 then 0xFF -> second start bit begins on the cycle after done. No gap; second frame bits are correct. tx_valid during the frame is ignored.
- Reset mid-frame: assert rst_n in DATA bit 3 -> tx=1 immediately. After release, a new 0x3C frame transmits correctly with no residue.
- UART_TX_BREAK_EN: brk_req high 20 cycles in IDLE (BAUD_DIV=4) -> tx=0 for 20 cycles, then tx=1 for 4 cycles before tx_ready=1. No done pulse.
